i2c_byte_ctrl: RTL and testbench
================================

Name: i2c_byte_ctrl

Overview:
Command-driven sequencer for the 8-bit shift_register in the I2C master datapath. Accepts START, STOP, WRITE-byte and READ-byte commands and generates SCL timing. Drives the shift register's load, shift and direction controls, and open-drain SDA enable. Returns the ACK/NACK status and the read byte through a one-cycle response pulse.

Parameters:
CLK_DIV, 4, clk cycles per SCL half-period (legal range >= 2)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset (sampled on rising clk)
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE; accept = cmd_valid & cmd_ready
cmd_op  in  2  0=START, 1=STOP, 2=WRITE, 3=READ
cmd_data  in  8  byte to transmit (WRITE)
cmd_nack  in  1  READ only: 1 = master NACKs (releases SDA in ACK slot)
rsp_valid  out  1  one-cycle completion pulse, every command
rsp_nack  out  1  WRITE: sampled slave ACK bit; otherwise 0
rsp_data  out  8  READ: captured byte; holds last value otherwise
busy  out  1  ~cmd_ready
sr_en_w  out  1  shift-register parallel load
sr_shift_en  out  1  shift-register one-bit shift strobe
sr_rw_en  out  1  0 = shift out (write), 1 = shift in (read)
sr_parallel_in  out  8  load data to the shift register
sr_parallel_out  in  8  shift-register contents
sr_sda_out  in  1  shift-register MSB serial output
sda_in  in  1  SDA line level
scl_out  out  1  SCL level
sda_oe  out  1  1 = pull SDA low; 0 = release

Behaviour:
- Reset values: scl_out=1, sda_oe=0, cmd_ready=1, rsp_valid=0, rsp_nack=0, rsp_data=0, sr_*=0, scl_hold=1, state=IDLE.
- Reset mid-operation aborts immediately. No response is issued. Bus is released (scl_out=1, sda_oe=0).
- Half-period timing: div_cnt clears on each state entry and counts 0..CLK_DIV-1. A tick occurs at CLK_DIV-1 and advances the state, so every phase state lasts exactly CLK_DIV cycles.
- Accept: the state changes on the clock after acceptance.
  - WRITE: sr_en_w=1 for the accept cycle only, with sr_parallel_in=cmd_data and sr_rw_en=0.
  - READ: sr_rw_en=1 from accept to DONE.
  - cmd_op and cmd_nack are registered at accept.
- IDLE: scl_out=scl_hold, sda_oe held from the previous phase.
- States and levels (SCL/SDA):
  - REP_A (0/released) -> REP_B (1/released) -> START_A. This prefix is entered only for START with scl_hold=0 (repeated start).
  - START_A (1/low) -> START_B (0/low) -> DONE. Sets scl_hold=0.
  - BIT_LO (0/data) -> BIT_HI (1/data). bit_cnt counts 0..7.
  - ACK_LO (0/ack) -> ACK_HI (1/ack) -> DONE.
  - STOP_A (0/low) -> STOP_B (1/low) -> STOP_C (1/released) -> DONE. Sets scl_hold=1.
  - DONE: one cycle, rsp_valid=1, then IDLE.
- WRITE data phase: sda_oe=~sr_sda_out in BIT_LO and BIT_HI. On the BIT_HI tick with bit_cnt<7, sr_shift_en=1 for one cycle (7 pulses per byte).
- WRITE ACK phase: SDA released. sda_in is sampled on the ACK_HI tick into rsp_nack.
- READ data phase: SDA released. On every BIT_HI tick, sr_shift_en=1 (8 pulses, shifting sda_in into LSB).
- READ ACK phase: sda_oe=~cmd_nack_r. rsp_data=sr_parallel_out captured on entry to DONE. rsp_nack=0.
- Latency from the accept cycle to the rsp_valid cycle:
  - START: 1+2*CLK_DIV (repeated start: 1+4*CLK_DIV).
  - STOP: 1+3*CLK_DIV.
  - WRITE/READ: 1+18*CLK_DIV.
- cmd_valid outside IDLE is ignored (not queued). A byte command without a preceding START is executed as normal. No arbitration or clock-stretching detection.

Decomposition:
- i2c_ctrl_pkg: op enum (OP_START, OP_STOP, OP_WRITE, OP_READ), state enum, BYTE_BITS=8.
- Sub-module i2c_clk_div: parameter CLK_DIV; inputs clk, rst_n, clr; output tick. The controller pulses clr on every state change.

Test Plan:
- Reset then START, CLK_DIV=4 -> SDA low with SCL=1 for 4 clks, then SCL=0; rsp_valid at accept+9, rsp_nack=0.
- WRITE 0xAB, slave holds sda_in=0 in ACK -> sr_en_w one pulse with 0xAB; sda_oe pattern over bits = ~1,0,1,0,1,0,1,1; 7 sr_shift_en pulses; rsp_valid at accept+73 with rsp_nack=0.
- WRITE 0x3C with sda_in=1 in ACK -> rsp_nack=1.
- READ with cmd_nack=1, sda_in bits 1,0,1,0,1,0,1,1, shift-register model -> 8 shift pulses with sr_rw_en=1; sda_oe=0 in ACK; rsp_data=0xAB.
- START after a byte (scl_hold=0) -> REP_A/REP_B prefix present; rsp_valid at accept+17. Then STOP -> SDA released while SCL=1; rsp at +13; scl_out=1 in IDLE.
- rst_n=0 during BIT_HI of a WRITE -> next clk: scl_out=1, sda_oe=0, cmd_ready=1, no rsp_valid. A following START completes normally.

Source files
------------

// File: rtl/i2c_ctrl_pkg.sv
// Shared types for the I2C byte controller: command opcodes, FSM states and
// the byte width handled per data command.
package i2c_ctrl_pkg;

  localparam int BYTE_BITS = 8;
  localparam int STATE_W   = 4;

  typedef enum logic [1:0] {
    OP_START = 2'd0,
    OP_STOP  = 2'd1,
    OP_WRITE = 2'd2,
    OP_READ  = 2'd3
  } op_t;

  // Each non-IDLE, non-DONE state is one SCL half-period long.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 4'd0,
    ST_REP_A   = 4'd1,
    ST_REP_B   = 4'd2,
    ST_START_A = 4'd3,
    ST_START_B = 4'd4,
    ST_BIT_LO  = 4'd5,
    ST_BIT_HI  = 4'd6,
    ST_ACK_LO  = 4'd7,
    ST_ACK_HI  = 4'd8,
    ST_STOP_A  = 4'd9,
    ST_STOP_B  = 4'd10,
    ST_STOP_C  = 4'd11,
    ST_DONE    = 4'd12
  } state_t;

endpackage

// File: rtl/i2c_clk_div.sv
// Half-period timer: counts 0..CLK_DIV-1 and flags the last count as a tick.
// clr restarts the count so a new phase always starts from zero.
module i2c_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  // Next count: wrap on tick, restart on clr.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/i2c_byte_ctrl.sv
// Command sequencer for an I2C master byte datapath. Generates SCL and the
// open-drain SDA enable for START / STOP / WRITE / READ, steers the external
// shift register and reports completion with a one-cycle response pulse.
//
// Handshake: a command is taken in the cycle where cmd_valid & cmd_ready are
// both high; cmd_ready is high only in IDLE, so requests raised while busy are
// dropped rather than queued. rsp_valid is a single-cycle pulse with no
// back-pressure; rsp_nack / rsp_data are valid in that cycle.
module i2c_byte_ctrl
  import i2c_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [BYTE_BITS-1:0] cmd_data,
  input  logic                 cmd_nack,
  output logic                 rsp_valid,
  output logic                 rsp_nack,
  output logic [BYTE_BITS-1:0] rsp_data,
  output logic                 busy,
  output logic                 sr_en_w,
  output logic                 sr_shift_en,
  output logic                 sr_rw_en,
  output logic [BYTE_BITS-1:0] sr_parallel_in,
  input  logic [BYTE_BITS-1:0] sr_parallel_out,
  input  logic                 sr_sda_out,
  input  logic                 sda_in,
  output logic                 scl_out,
  output logic                 sda_oe,
  output logic [STATE_W-1:0]   dbg_state
);

  localparam logic [2:0] LAST_BIT = 3'(BYTE_BITS - 1);

  state_t               state_q;
  op_t                  op_q;
  logic                 nack_q;
  logic [2:0]           bit_cnt_q;
  logic                 scl_q;
  logic                 sda_oe_q;
  logic                 scl_hold_q;
  logic                 rsp_valid_q;
  logic                 rsp_nack_q;
  logic [BYTE_BITS-1:0] rsp_data_q;

  logic tick;
  logic clr;
  logic accept;
  logic phase_tick;
  logic wr_data_phase;

  assign cmd_ready  = (state_q == ST_IDLE);
  assign busy       = ~cmd_ready;
  assign accept     = rst_n & cmd_valid & cmd_ready;
  assign phase_tick = tick & (state_q != ST_IDLE) & (state_q != ST_DONE);
  // Every state change restarts the half-period timer.
  assign clr        = accept | phase_tick | (state_q == ST_DONE);

  i2c_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .tick (tick)
  );

  // While a byte is being written the SDA driver follows the shift register
  // MSB directly, so the freshly shifted bit is on the line at BIT_LO entry.
  assign wr_data_phase = (op_q == OP_WRITE) &&
                         ((state_q == ST_BIT_LO) || (state_q == ST_BIT_HI));

  assign sr_en_w        = accept & (cmd_op == OP_WRITE);
  assign sr_parallel_in = sr_en_w ? cmd_data : '0;
  assign sr_rw_en       = rst_n & ((accept & (cmd_op == OP_READ)) |
                                   ((state_q != ST_IDLE) & (op_q == OP_READ)));
  // Write shifts after bits 0..6 only; read shifts in all 8 sampled bits.
  assign sr_shift_en    = rst_n & (state_q == ST_BIT_HI) & tick &
                          ((op_q == OP_READ) | (bit_cnt_q != LAST_BIT));

  assign scl_out   = scl_q;
  assign sda_oe    = wr_data_phase ? ~sr_sda_out : sda_oe_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_nack  = rsp_nack_q;
  assign rsp_data  = rsp_data_q;
  assign dbg_state = state_q;

  // Sequencer: state, bus levels and response registers updated on entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_START;
      nack_q      <= 1'b0;
      bit_cnt_q   <= '0;
      scl_q       <= 1'b1;
      sda_oe_q    <= 1'b0;
      scl_hold_q  <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_nack_q  <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q       <= op_t'(cmd_op);
            nack_q     <= cmd_nack;
            bit_cnt_q  <= '0;
            rsp_nack_q <= 1'b0;
            case (op_t'(cmd_op))
              OP_START: begin
                if (scl_hold_q) begin
                  state_q    <= ST_START_A;
                  scl_q      <= 1'b1;
                  sda_oe_q   <= 1'b1;
                  scl_hold_q <= 1'b0;
                end else begin
                  // SCL is parked low: release SDA and raise SCL first.
                  state_q  <= ST_REP_A;
                  scl_q    <= 1'b0;
                  sda_oe_q <= 1'b0;
                end
              end
              OP_STOP: begin
                state_q  <= ST_STOP_A;
                scl_q    <= 1'b0;
                sda_oe_q <= 1'b1;
              end
              default: begin
                state_q  <= ST_BIT_LO;
                scl_q    <= 1'b0;
                sda_oe_q <= 1'b0;
              end
            endcase
          end
        end
        ST_REP_A: begin
          if (tick) begin
            state_q <= ST_REP_B;
            scl_q   <= 1'b1;
          end
        end
        ST_REP_B: begin
          if (tick) begin
            state_q    <= ST_START_A;
            sda_oe_q   <= 1'b1;
            scl_hold_q <= 1'b0;
          end
        end
        ST_START_A: begin
          if (tick) begin
            state_q <= ST_START_B;
            scl_q   <= 1'b0;
          end
        end
        ST_START_B: begin
          if (tick) begin
            state_q     <= ST_DONE;
            rsp_valid_q <= 1'b1;
          end
        end
        ST_BIT_LO: begin
          if (tick) begin
            state_q <= ST_BIT_HI;
            scl_q   <= 1'b1;
          end
        end
        ST_BIT_HI: begin
          if (tick) begin
            scl_q <= 1'b0;
            if (bit_cnt_q == LAST_BIT) begin
              state_q  <= ST_ACK_LO;
              sda_oe_q <= (op_q == OP_READ) ? ~nack_q : 1'b0;
            end else begin
              state_q   <= ST_BIT_LO;
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end
        ST_ACK_LO: begin
          if (tick) begin
            state_q <= ST_ACK_HI;
            scl_q   <= 1'b1;
          end
        end
        ST_ACK_HI: begin
          if (tick) begin
            state_q     <= ST_DONE;
            rsp_valid_q <= 1'b1;
            if (op_q == OP_READ) begin
              rsp_data_q <= sr_parallel_out;
            end else begin
              rsp_nack_q <= sda_in;
            end
          end
        end
        ST_STOP_A: begin
          if (tick) begin
            state_q <= ST_STOP_B;
            scl_q   <= 1'b1;
          end
        end
        ST_STOP_B: begin
          if (tick) begin
            state_q    <= ST_STOP_C;
            sda_oe_q   <= 1'b0;
            scl_hold_q <= 1'b1;
          end
        end
        ST_STOP_C: begin
          if (tick) begin
            state_q     <= ST_DONE;
            rsp_valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          scl_q   <= scl_hold_q;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_byte_ctrl.sv
// Bench for i2c_byte_ctrl with CLK_DIV=4: directed commands, a behavioural
// shift register and slave, and a response scoreboard.
module tb_i2c_byte_ctrl;
  import i2c_ctrl_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int W       = 9;  // {rsp_data, rsp_nack}

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       cmd_nack;
  logic       rsp_valid;
  logic       rsp_nack;
  logic [7:0] rsp_data;
  logic       busy;
  logic       sr_en_w;
  logic       sr_shift_en;
  logic       sr_rw_en;
  logic [7:0] sr_parallel_in;
  logic [7:0] sr_parallel_out;
  logic       sr_sda_out;
  logic       sda_in;
  logic       scl_out;
  logic       sda_oe;
  logic [3:0] dbg_state;

  logic [7:0] sr_q;
  int         cyc;
  int         total;
  int         bad;

  logic [W-1:0] exp_q[$];
  int           exp_t_q[$];

  // observations of the most recent command
  int         obs_shift;
  int         obs_enw;
  int         obs_rw_low;
  int         obs_rises;
  int         obs_hi_low;
  int         obs_hi_rel;
  logic [7:0] obs_oe;
  logic       obs_oe_ack;
  logic       obs_acc_enw;
  logic [7:0] obs_acc_pin;
  logic       obs_acc_rw;

  i2c_byte_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_data       (cmd_data),
    .cmd_nack       (cmd_nack),
    .rsp_valid      (rsp_valid),
    .rsp_nack       (rsp_nack),
    .rsp_data       (rsp_data),
    .busy           (busy),
    .sr_en_w        (sr_en_w),
    .sr_shift_en    (sr_shift_en),
    .sr_rw_en       (sr_rw_en),
    .sr_parallel_in (sr_parallel_in),
    .sr_parallel_out(sr_parallel_out),
    .sr_sda_out     (sr_sda_out),
    .sda_in         (sda_in),
    .scl_out        (scl_out),
    .sda_oe         (sda_oe),
    .dbg_state      (dbg_state)
  );

  // clock / reset-independent cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // behavioural 8-bit shift register the controller steers
  always @(posedge clk) begin
    if (sr_en_w) sr_q <= sr_parallel_in;
    else if (sr_shift_en) sr_q <= sr_rw_en ? {sr_q[6:0], sda_in} : {sr_q[6:0], 1'b0};
  end
  assign sr_parallel_out = sr_q;
  assign sr_sda_out      = sr_q[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: pops one expectation per response pulse
  initial begin : monitor
    logic [W-1:0] e;
    int           et;
    forever begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rsp: got rsp at cycle %0d, want none", cyc);
        end else begin
          e  = exp_q.pop_front();
          et = exp_t_q.pop_front();
          chk("rsp_value", {rsp_data, rsp_nack}, e);
          chk("rsp_cycle", cyc, et);
        end
      end
    end
  end

  // Issue one command, act as slave on sda_in, record bus behaviour until rsp.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] data, input logic nack,
                         input logic [7:0] slv_byte, input logic slv_ack, input int lat,
                         input logic [W-1:0] exp_rsp, input int hold_cycles);
    int   acc;
    logic prev_scl;
    bit   done;
    @(negedge clk);
    chk("ready_before_cmd", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_nack  = nack;
    sda_in    = slv_byte[7];
    #1;
    acc         = cyc;
    obs_acc_enw = sr_en_w;
    obs_acc_pin = sr_parallel_in;
    obs_acc_rw  = sr_rw_en;
    prev_scl    = scl_out;
    exp_q.push_back(exp_rsp);
    exp_t_q.push_back(acc + lat);
    obs_shift = 0; obs_enw = 0; obs_rw_low = 0; obs_rises = 0;
    obs_hi_low = 0; obs_hi_rel = 0; obs_oe = 8'h00; obs_oe_ack = 1'b0;
    done = 0;
    @(posedge clk);
    for (int n = 0; n < lat + 5 && !done; n++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        done = 1;
      end else begin
        if (sr_shift_en) obs_shift++;
        if (sr_en_w) obs_enw++;
        if (!sr_rw_en) obs_rw_low++;
        if (scl_out && sda_oe) obs_hi_low++;
        if (scl_out && !sda_oe) obs_hi_rel++;
        if (scl_out && !prev_scl) begin
          if (obs_rises < 8) obs_oe[7 - obs_rises] = sda_oe;
          else if (obs_rises == 8) obs_oe_ack = sda_oe;
          obs_rises++;
        end
        prev_scl = scl_out;
        if (!scl_out) sda_in = (obs_rises < 8) ? slv_byte[7 - obs_rises] : slv_ack;
      end
      if (n >= hold_cycles) cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0;
    chk("rsp_within_budget", done, 1'b1);
    @(negedge clk);
    chk("rsp_one_cycle", rsp_valid, 1'b0);
    chk("ready_after_cmd", cmd_ready, 1'b1);
  endtask

  // Start a WRITE and pull reset during the first SCL-high bit phase.
  task automatic abort_write(input logic [7:0] data);
    logic prev;
    bit   hit;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = OP_WRITE;
    cmd_data  = data;
    cmd_nack  = 1'b0;
    prev      = scl_out;
    @(posedge clk);
    hit = 0;
    for (int n = 0; n < 40 && !hit; n++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (scl_out && !prev) hit = 1;
      prev = scl_out;
    end
    chk("abort_reached_bit_hi", hit, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_scl", scl_out, 1'b1);
    chk("abort_sda_oe", sda_oe, 1'b0);
    chk("abort_ready", cmd_ready, 1'b1);
    chk("abort_no_rsp", rsp_valid, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle_rsp", rsp_valid, 1'b0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, want test end");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    total = 0; bad = 0; cyc = 0; sr_q = 8'h00;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = 8'h00;
    cmd_nack = 1'b0; sda_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_scl", scl_out, 1'b1);
    chk("rst_sda_oe", sda_oe, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp", {rsp_data, rsp_nack}, 9'h000);
    chk("rst_sr_ctrl", {sr_en_w, sr_shift_en, sr_rw_en, sr_parallel_in}, 11'h000);
    chk("rst_state", dbg_state, 4'd0);
    rst_n = 1'b1;

    // START from released bus: 1 + 2*4 = 9
    run_cmd(OP_START, 8'h00, 1'b0, 8'hFF, 1'b1, 9, {8'h00, 1'b0}, 0);
    chk("start_sda_low_scl_high", obs_hi_low, 4);
    chk("start_no_prefix", obs_rises, 0);
    chk("start_idle_scl", scl_out, 1'b0);
    chk("start_idle_sda", sda_oe, 1'b1);

    // WRITE 0xAB, slave ACKs: 1 + 18*4 = 73
    run_cmd(OP_WRITE, 8'hAB, 1'b0, 8'hFF, 1'b0, 73, {8'h00, 1'b0}, 0);
    chk("wr_ab_load", {obs_acc_enw, obs_acc_rw, obs_acc_pin}, {1'b1, 1'b0, 8'hAB});
    chk("wr_ab_single_load", obs_enw, 0);
    chk("wr_ab_oe_bits", obs_oe, 8'h54);
    chk("wr_ab_oe_ack", obs_oe_ack, 1'b0);
    chk("wr_ab_shifts", obs_shift, 7);

    // WRITE 0x3C, slave NACKs; cmd_valid held while busy must be ignored
    run_cmd(OP_WRITE, 8'h3C, 1'b0, 8'hFF, 1'b1, 73, {8'h00, 1'b1}, 10);
    chk("wr_3c_oe_bits", obs_oe, 8'hC3);
    chk("wr_3c_shifts", obs_shift, 7);
    chk("wr_3c_no_reload", obs_enw, 0);

    // READ 0xAB with master NACK
    run_cmd(OP_READ, 8'h00, 1'b1, 8'hAB, 1'b1, 73, {8'hAB, 1'b0}, 0);
    chk("rd_ab_shifts", obs_shift, 8);
    chk("rd_ab_rw_acc", obs_acc_rw, 1'b1);
    chk("rd_ab_rw_held", obs_rw_low, 0);
    chk("rd_ab_no_load", obs_acc_enw, 1'b0);
    chk("rd_ab_oe_bits", obs_oe, 8'h00);
    chk("rd_ab_oe_ack", obs_oe_ack, 1'b0);

    // READ 0x5C with master ACK
    run_cmd(OP_READ, 8'h00, 1'b0, 8'h5C, 1'b1, 73, {8'h5C, 1'b0}, 0);
    chk("rd_5c_oe_ack", obs_oe_ack, 1'b1);
    chk("rd_5c_shifts", obs_shift, 8);

    // repeated START: 1 + 4*4 = 17
    run_cmd(OP_START, 8'h00, 1'b0, 8'hFF, 1'b1, 17, {8'h5C, 1'b0}, 0);
    chk("rstart_prefix", obs_rises, 1);
    chk("rstart_sda_low_scl_high", obs_hi_low, 4);

    // STOP: 1 + 3*4 = 13
    run_cmd(OP_STOP, 8'h00, 1'b0, 8'hFF, 1'b1, 13, {8'h5C, 1'b0}, 0);
    chk("stop_low_scl_high", obs_hi_low, 4);
    chk("stop_release_scl_high", obs_hi_rel, 4);
    chk("stop_idle_scl", scl_out, 1'b1);
    chk("stop_idle_sda", sda_oe, 1'b0);

    // reset mid-byte, then a clean START (rsp_data cleared by reset)
    abort_write(8'h5A);
    run_cmd(OP_START, 8'h00, 1'b0, 8'hFF, 1'b1, 9, {8'h00, 1'b0}, 0);
    chk("post_abort_no_prefix", obs_rises, 0);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
